rf_writeback: RTL and testbench
===============================

# rf_writeback

Write-side front end for the 32×32 register file: merges the pipeline's single-cycle writeback stream (port A) with a buffered stream from slow units such as loads and mul/div (port B). It emits at most one register-file write per cycle on a registered write port. It also publishes a per-register pending scoreboard so the hazard logic can stall readers of registers that still have a queued write. The block sits between the writeback stage / slow units and the register file write pins (write enable, write address, write data).

## Interface
- `DEPTH`, 4: port-B FIFO entries; power of 2, at least 2.
- `STARVE_MAX`, 8: consecutive cycles a non-empty FIFO may be blocked by port A before `stall_o` is raised.
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_n_i`  in  1  reset; asynchronous, active-low.
- `wb_valid_i`  in  1  port A write request; always accepted, no backpressure.
- `wb_rd_i`  in  5  port A destination register.
- `wb_data_i`  in  32  port A write data.
- `sec_valid_i`  in  1  port B request.
- `sec_ready_o`  out  1  port B can accept; equals FIFO not full.
- `sec_rd_i`  in  5  port B destination register.
- `sec_data_i`  in  32  port B write data.
- `rf_we_o`  out  1  register-file write enable (registered).
- `rf_wr_o`  out  5  register-file write address (registered).
- `rf_wd_o`  out  32  register-file write data (registered).
- `pending_o`  out  32  bit r is set while a write to r is queued or sitting in the output register. Bit 0 is always 0.
- `stall_o`  out  1  registered request for a one-cycle port-A bubble.

## Operation
- **Port B handshake:** a transfer happens when `sec_valid_i` and `sec_ready_o` are both high at a rising edge. Requests with rd=0 are accepted but not stored.
- **Port A, rd=0:** the request is ignored; no write is issued.
- **Selection each cycle, priority order:**
  - Port A valid with rd≠0: output register loads A; `rf_we_o` is 1 next cycle.
  - Otherwise, FIFO non-empty: the head is popped and loaded into the output register.
  - Otherwise: `rf_we_o` is 0 next cycle; address and data hold their previous values.
- **Ordering contract:** port A is always younger than every queued port-B entry. A valid port-A write to rd kills, in the same cycle, every live FIFO entry with that rd.
  - Killed entries stay in place and are popped later without producing a write.
  - Killed entries still occupy capacity until popped.
- **Scoreboard:** `pending_o` is combinational. It is the OR of decode(rd) over live FIFO entries, plus decode(`rf_wr_o`) when `rf_we_o`=1.
- **Starvation guard:**
  - Counter `starve` increments in each cycle where the FIFO is non-empty and port A wins.
  - It clears when the FIFO pops or is empty.
  - When `starve` reaches STARVE_MAX-1 and increments, `stall_o`=1 in the next cycle and `starve` clears.
  - Upstream must hold `wb_valid_i`=0 while `stall_o`=1. If it does not, port A still wins and counting resumes.
- **Full FIFO:** `sec_ready_o`=0. There is no same-cycle pop-then-push pass-through.

## Timing
- **Reset:** while `rst_n_i`=0, all of the following are 0: `rf_we_o`, `rf_wr_o`, `rf_wd_o`, `stall_o`, FIFO count, pointers, live bits, `starve`, `pending_o`. `sec_ready_o` is 1.
- **Reset mid-operation:** queued writes are discarded.
- **Port A latency:** request in cycle N gives `rf_we_o` in N+1; the register file updates at the edge ending N+1.
- **Port B latency:** accepted at the edge ending N; earliest `rf_we_o` is N+2 if port A is idle in N+1.
- **Throughput:** one register-file write per cycle. Port B alone sustains one write per cycle once the FIFO is primed.
- **Simultaneous push and pop (FIFO not full):** both occur; count is unchanged.
- **Simultaneous port-A kill and port-B push of the same rd:** the kill applies only to entries already stored. The new entry is live.
- **Pointer wrap:** modulo DEPTH. Count ranges 0..DEPTH.

## Structure
- **Package `rf_wb_pkg`:**
  - `REG_W`=5, `DATA_W`=32, `NREG`=32.
  - `wb_entry_t` with fields rd, data, live.
  - Function `rd_onehot(rd)` returning 32 bits with bit 0 forced to 0.
- **Sub-module `wb_fifo`:** synchronous FIFO of `wb_entry_t` with push/pop, full/empty and count. It has a kill-by-rd input that clears live bits, and exports the live-rd one-hot OR used by `pending_o`.
- **Top level:** selection mux, output register and starvation counter.

## Test plan
- **Reset state:** assert `rst_n_i`=0 mid-stream with 3 entries queued. Outputs and `pending_o` are 0 immediately; after release, `sec_ready_o`=1 and no write issues.
- **Port A only:** rd=5, data=0xDEADBEEF in cycle N. Cycle N+1 shows `rf_we_o`=1, `rf_wr_o`=5, `rf_wd_o`=0xDEADBEEF. Any rd=0 request yields `rf_we_o`=0.
- **Port B fill/drain:** port A held busy while 4 pushes arrive (rd 1..4). `sec_ready_o` drops after the 4th and `pending_o`=0x1E. Releasing port A drains rd 1,2,3,4 in order on consecutive cycles, and `pending_o` clears bit by bit.
- **Kill:** queue rd=7 data 0x11, then port A writes rd=7 data 0x22. Only 0x22 is written to reg 7. The killed pop cycle shows `rf_we_o`=0.
- **Starvation:** FIFO holds 1 entry and port A is valid for 8 cycles. `stall_o`=1 in the 9th cycle; with port A idle then, the entry writes one cycle later.
- **Random soak:** random A/B traffic checked against a reference model of the register-file contents and `pending_o` every cycle.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared widths, the queued-write entry type and the register one-hot decoder
// used by the register-file writeback front end.
package rf_wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic              live;
    } wb_entry_t;

    // x0 is hardwired, so it never shows up as pending.
    function automatic logic [NREG-1:0] rd_onehot(input logic [REG_W-1:0] rd);
        logic [NREG-1:0] oh;
        oh     = '0;
        oh[rd] = 1'b1;
        oh[0]  = 1'b0;
        return oh;
    endfunction

endpackage

// File: rtl/rf_writeback_if.sv
// Bundle of the writeback ports: port A stream, port B handshake,
// register-file write pins, pending scoreboard and stall request.
interface rf_writeback_if;
    import rf_wb_pkg::*;

    logic              wb_valid_i;
    logic [REG_W-1:0]  wb_rd_i;
    logic [DATA_W-1:0] wb_data_i;

    logic              sec_valid_i;
    logic              sec_ready_o;
    logic [REG_W-1:0]  sec_rd_i;
    logic [DATA_W-1:0] sec_data_i;

    logic              rf_we_o;
    logic [REG_W-1:0]  rf_wr_o;
    logic [DATA_W-1:0] rf_wd_o;
    logic [NREG-1:0]   pending_o;
    logic              stall_o;

    modport slave (
        input  wb_valid_i, wb_rd_i, wb_data_i,
        input  sec_valid_i, sec_rd_i, sec_data_i,
        output sec_ready_o,
        output rf_we_o, rf_wr_o, rf_wd_o, pending_o, stall_o
    );

    modport master (
        output wb_valid_i, wb_rd_i, wb_data_i,
        output sec_valid_i, sec_rd_i, sec_data_i,
        input  sec_ready_o,
        input  rf_we_o, rf_wr_o, rf_wd_o, pending_o, stall_o
    );

endinterface

// File: rtl/wb_fifo.sv
// Purpose: port-B write queue with per-entry live bits, kill-by-rd and live-rd one-hot.
// Latency: pushed entry is visible at the head the cycle after the push.
// Backpressure: full when count reaches DEPTH; push while full or pop while empty is ignored.
module wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_vld,
    input  wb_entry_t                push_dat,
    input  logic                     pop_vld,
    input  logic                     kill_vld,
    input  logic [REG_W-1:0]         kill_rd,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output wb_entry_t                head_dat,
    output logic [NREG-1:0]          live_mask
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count_q;
    logic [DEPTH-1:0]  live_q;
    logic [DEPTH-1:0]  live_nxt;
    logic [REG_W-1:0]  rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic              do_push;
    logic              do_pop;
    logic              empty;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;
    assign count   = count_q;

    // A freed slot always has live=0, so live alone marks a queued write.
    // The push is applied last: a same-cycle kill only hits older entries.
    always_comb begin
        live_nxt = live_q;
        if (kill_vld) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_mem[i] == kill_rd) live_nxt[i] = 1'b0;
            end
        end
        if (do_pop)  live_nxt[rd_ptr] = 1'b0;
        if (do_push) live_nxt[wr_ptr] = push_dat.live;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            live_q  <= '0;
        end else begin
            live_q <= live_nxt;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            rd_mem[wr_ptr]   <= push_dat.rd;
            data_mem[wr_ptr] <= push_dat.data;
        end
    end

    always_comb begin
        head_dat.rd   = rd_mem[rd_ptr];
        head_dat.data = data_mem[rd_ptr];
        head_dat.live = live_q[rd_ptr];
    end

    always_comb begin
        live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) live_mask = live_mask | rd_onehot(rd_mem[i]);
        end
    end

endmodule

// File: rtl/rf_writeback.sv
// Purpose: merge port A writeback and queued port B writes into one registered RF write port.
// Latency: port A 1 cycle to rf_we_o; port B at least 2 cycles (FIFO then output register).
// Backpressure: port A never stalled directly (stall_o is advisory); port B ready = FIFO not full.
module rf_writeback
    import rf_wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    rf_writeback_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX);

    logic              a_win;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;
    logic              fifo_nonempty;
    logic              fifo_push;
    logic              fifo_pop;
    wb_entry_t         push_dat;
    wb_entry_t         head_dat;
    logic [NREG-1:0]   fifo_live_mask;

    logic              rf_we_q;
    logic [REG_W-1:0]  rf_wr_q;
    logic [DATA_W-1:0] rf_wd_q;
    logic [SW-1:0]     starve_q;
    logic              stall_q;

    assign a_win         = bus.wb_valid_i && (bus.wb_rd_i != '0);
    assign fifo_nonempty = (fifo_count != '0);
    assign fifo_pop      = !a_win && fifo_nonempty;
    // x0 requests complete the handshake but are dropped here.
    assign fifo_push     = bus.sec_valid_i && !fifo_full && (bus.sec_rd_i != '0);

    always_comb begin
        push_dat.rd   = bus.sec_rd_i;
        push_dat.data = bus.sec_data_i;
        push_dat.live = 1'b1;
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push_vld  (fifo_push),
        .push_dat  (push_dat),
        .pop_vld   (fifo_pop),
        .kill_vld  (a_win),
        .kill_rd   (bus.wb_rd_i),
        .full      (fifo_full),
        .count     (fifo_count),
        .head_dat  (head_dat),
        .live_mask (fifo_live_mask)
    );

    // A killed head is still popped, but address/data hold.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rf_we_q <= 1'b0;
            rf_wr_q <= '0;
            rf_wd_q <= '0;
        end else if (a_win) begin
            rf_we_q <= 1'b1;
            rf_wr_q <= bus.wb_rd_i;
            rf_wd_q <= bus.wb_data_i;
        end else if (fifo_pop && head_dat.live) begin
            rf_we_q <= 1'b1;
            rf_wr_q <= head_dat.rd;
            rf_wd_q <= head_dat.data;
        end else begin
            rf_we_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else if (a_win && fifo_nonempty) begin
            if (starve_q == SW'(STARVE_MAX - 1)) begin
                starve_q <= '0;
                stall_q  <= 1'b1;
            end else begin
                starve_q <= starve_q + 1'b1;
                stall_q  <= 1'b0;
            end
        end else begin
            starve_q <= '0;
            stall_q  <= 1'b0;
        end
    end

    assign bus.sec_ready_o = !fifo_full;
    assign bus.rf_we_o     = rf_we_q;
    assign bus.rf_wr_o     = rf_wr_q;
    assign bus.rf_wd_o     = rf_wd_q;
    assign bus.stall_o     = stall_q;
    assign bus.pending_o   = fifo_live_mask | (rf_we_q ? rd_onehot(rf_wr_q) : '0);

endmodule

// File: tb/tb_rf_writeback.sv
// Directed and random checks of rf_writeback against a queue-based reference model.
module tb_rf_writeback;
    import rf_wb_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_writeback_if bus ();

    rf_writeback #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } m_ent_t;

    m_ent_t      q[$];
    logic        exp_we;
    logic [4:0]  exp_wr;
    logic [31:0] exp_wd;
    logic        exp_stall;
    int          blocked;
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf   [32];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] p;
        p = '0;
        foreach (q[i]) if (q[i].live) p[q[i].rd] = 1'b1;
        if (exp_we) p[exp_wr] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_we    = 1'b0;
        exp_wr    = '0;
        exp_wd    = '0;
        exp_stall = 1'b0;
        blocked   = 0;
    endtask

    // Next-cycle expectations from the current inputs: A is youngest and wins,
    // else the oldest queued write drains; a push lands after any kill.
    task automatic model_step();
        m_ent_t e;
        bit a_win, b_xfer, nonempty;
        a_win    = bus.wb_valid_i && (bus.wb_rd_i != 5'd0);
        b_xfer   = bus.sec_valid_i && (q.size() < DEPTH);
        nonempty = (q.size() != 0);
        exp_stall = 1'b0;
        if (a_win) begin
            foreach (q[i]) if (q[i].rd == bus.wb_rd_i) q[i].live = 1'b0;
            exp_we = 1'b1;
            exp_wr = bus.wb_rd_i;
            exp_wd = bus.wb_data_i;
            if (nonempty) begin
                blocked++;
                if (blocked == STARVE_MAX) begin
                    exp_stall = 1'b1;
                    blocked   = 0;
                end
            end else begin
                blocked = 0;
            end
        end else if (nonempty) begin
            e = q.pop_front();
            exp_we = e.live;
            if (e.live) begin
                exp_wr = e.rd;
                exp_wd = e.data;
            end
            blocked = 0;
        end else begin
            exp_we  = 1'b0;
            blocked = 0;
        end
        if (b_xfer && bus.sec_rd_i != 5'd0)
            q.push_back('{rd: bus.sec_rd_i, data: bus.sec_data_i, live: 1'b1});
        if (exp_we) model_rf[exp_wr] = exp_wd;
    endtask

    task automatic check_all();
        chk("rf_we", 32'(bus.rf_we_o), 32'(exp_we));
        if (exp_we) begin
            chk("rf_wr", 32'(bus.rf_wr_o), 32'(exp_wr));
            chk("rf_wd", bus.rf_wd_o, exp_wd);
        end
        chk("pending", bus.pending_o, exp_pending());
        chk("stall", 32'(bus.stall_o), 32'(exp_stall));
        chk("sec_ready", 32'(bus.sec_ready_o), 32'(q.size() < DEPTH));
        if (bus.rf_we_o) dut_rf[bus.rf_wr_o] = bus.rf_wd_o;
    endtask

    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic bv, input logic [4:0] brd, input logic [31:0] bd);
        bus.wb_valid_i  = av;
        bus.wb_rd_i     = ard;
        bus.wb_data_i   = ad;
        bus.sec_valid_i = bv;
        bus.sec_rd_i    = brd;
        bus.sec_data_i  = bd;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    logic [31:0] drain_pend [4];
    int          pa;

    initial begin
        bus.wb_valid_i  = 1'b0;
        bus.wb_rd_i     = '0;
        bus.wb_data_i   = '0;
        bus.sec_valid_i = 1'b0;
        bus.sec_rd_i    = '0;
        bus.sec_data_i  = '0;
        for (int r = 0; r < 32; r++) begin
            model_rf[r] = '0;
            dut_rf[r]   = '0;
        end
        model_reset();

        // Reset state
        #1;
        chk("rst_we", 32'(bus.rf_we_o), 32'd0);
        chk("rst_wr", 32'(bus.rf_wr_o), 32'd0);
        chk("rst_wd", bus.rf_wd_o, 32'd0);
        chk("rst_stall", 32'(bus.stall_o), 32'd0);
        chk("rst_pending", bus.pending_o, 32'd0);
        chk("rst_ready", 32'(bus.sec_ready_o), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Port A only, then an x0 request and an x0 port-B push
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        chk("a_we", 32'(bus.rf_we_o), 32'd1);
        chk("a_wr", 32'(bus.rf_wr_o), 32'd5);
        chk("a_wd", bus.rf_wd_o, 32'hDEADBEEF);
        cycle(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0);
        chk("a_x0_we", 32'(bus.rf_we_o), 32'd0);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
        idle();
        chk("b_x0_we", 32'(bus.rf_we_o), 32'd0);
        chk("b_x0_pend", bus.pending_o, 32'd0);

        // Fill with port A busy, then drain in order
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 5'd20, 32'hA0 + 32'(i), 1'b1, 5'(i), 32'hB0 + 32'(i));
        chk("fill_ready", 32'(bus.sec_ready_o), 32'd0);
        chk("fill_pend", bus.pending_o, 32'h0010_001E);
        drain_pend = '{32'h1E, 32'h1C, 32'h18, 32'h10};
        for (int i = 1; i <= 4; i++) begin
            idle();
            chk("drain_wr", 32'(bus.rf_wr_o), 32'(i));
            chk("drain_wd", bus.rf_wd_o, 32'hB0 + 32'(i));
            chk("drain_pend", bus.pending_o, drain_pend[i-1]);
        end
        idle();
        chk("drain_done", bus.pending_o, 32'd0);

        // Kill of a queued write by a younger port-A write
        cycle(1'b1, 5'd20, 32'h0, 1'b1, 5'd7, 32'h11);
        cycle(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0);
        chk("kill_wd", bus.rf_wd_o, 32'h22);
        chk("kill_pend", bus.pending_o, 32'h80);
        idle();
        chk("kill_pop_we", 32'(bus.rf_we_o), 32'd0);
        chk("kill_reg7", dut_rf[7], 32'h22);

        // Starvation guard
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < STARVE_MAX; i++) begin
            cycle(1'b1, 5'd21, 32'(i), 1'b0, 5'd0, 32'd0);
            if (i == STARVE_MAX - 2) chk("starve_pre", 32'(bus.stall_o), 32'd0);
        end
        chk("starve_stall", 32'(bus.stall_o), 32'd1);
        idle();
        chk("starve_wr", 32'(bus.rf_wr_o), 32'd9);
        chk("starve_clr", 32'(bus.stall_o), 32'd0);

        // Random soak with alternating port-A pressure
        for (int i = 0; i < 2000; i++) begin
            pa = ((i / 250) % 2 == 1) ? 90 : 40;
            cycle(($urandom_range(0, 99) < pa) && !(bus.stall_o && $urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom);
        end

        // Reset with three writes queued
        for (int i = 1; i <= 3; i++)
            cycle(1'b1, 5'd20, 32'hC0, 1'b1, 5'(i + 10), 32'hD0 + 32'(i));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_we", 32'(bus.rf_we_o), 32'd0);
        chk("mrst_wd", bus.rf_wd_o, 32'd0);
        chk("mrst_pend", bus.pending_o, 32'd0);
        chk("mrst_stall", 32'(bus.stall_o), 32'd0);
        chk("mrst_ready", 32'(bus.sec_ready_o), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        chk("mrst_nowrite", 32'(bus.rf_we_o), 32'd0);
        idle();

        for (int r = 0; r < 32; r++) chk("rf_reg", dut_rf[r], model_rf[r]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
